// File: rtl/crypto_cmd_sequencer.sv
// Converts front-panel command levels into one-cycle engine starts. It then tracks
// the engine's done handshake with ordering rules, a timeout and sticky error status.
module crypto_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gen,
  input  logic       encrypt,
  input  logic       decrypt,
  input  logic       gen_done,
  input  logic       enc_done,
  input  logic       dec_done,
  output logic       gen_start,
  output logic       enc_start,
  output logic       dec_start,
  output logic       busy,
  output logic       cmd_ok,
  output logic       key_valid,
  output logic       ct_valid,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYGEN,
    S_ENC,
    S_DEC,
    S_DONE
  } state_t;

  localparam logic [1:0]       ERR_NONE      = 2'd0;
  localparam logic [1:0]       ERR_TIMEOUT   = 2'd1;
  localparam logic [1:0]       ERR_NOT_READY = 2'd2;
  localparam logic [CNT_W-1:0] CNT_TERM      = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gen_q, enc_q, dec_q;
  logic             gen_edge, enc_edge, dec_edge;
  logic             op_done;
  logic             gen_start_d, enc_start_d, dec_start_d;
  logic             busy_d, cmd_ok_d;
  logic             key_valid_d, ct_valid_d;
  logic [1:0]       err_code_d;

  assign gen_edge = gen & ~gen_q;
  assign enc_edge = encrypt & ~enc_q;
  assign dec_edge = decrypt & ~dec_q;

  // Next-state and next-output logic; every register is computed here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid;
    ct_valid_d  = ct_valid;
    err_code_d  = err_code;
    gen_start_d = 1'b0;
    enc_start_d = 1'b0;
    dec_start_d = 1'b0;
    op_done     = ((state_q == S_KEYGEN) && gen_done) ||
                  ((state_q == S_ENC)    && enc_done) ||
                  ((state_q == S_DEC)    && dec_done);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (gen_edge) begin
          state_d     = S_KEYGEN;
          gen_start_d = 1'b1;
          key_valid_d = 1'b0;
          ct_valid_d  = 1'b0;
          err_code_d  = ERR_NONE;
        end else if (enc_edge) begin
          if (key_valid) begin
            state_d     = S_ENC;
            enc_start_d = 1'b1;
            ct_valid_d  = 1'b0;
            err_code_d  = ERR_NONE;
          end else begin
            err_code_d = ERR_NOT_READY;
          end
        end else if (dec_edge) begin
          if (ct_valid) begin
            state_d     = S_DEC;
            dec_start_d = 1'b1;
            err_code_d  = ERR_NONE;
          end else begin
            err_code_d = ERR_NOT_READY;
          end
        end
      end

      // Done beats the timeout terminal count when both land in the same cycle.
      S_KEYGEN, S_ENC, S_DEC: begin
        if (op_done) begin
          state_d = S_DONE;
          if (state_q == S_KEYGEN) key_valid_d = 1'b1;
          if (state_q == S_ENC)    ct_valid_d  = 1'b1;
        end else if (cnt_q == CNT_TERM) begin
          state_d    = S_IDLE;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    cmd_ok_d = (state_d == S_DONE);
  end

  // Command history resets high so levels held through reset never fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gen_q     <= 1'b1;
      enc_q     <= 1'b1;
      dec_q     <= 1'b1;
      gen_start <= 1'b0;
      enc_start <= 1'b0;
      dec_start <= 1'b0;
      busy      <= 1'b0;
      cmd_ok    <= 1'b0;
      key_valid <= 1'b0;
      ct_valid  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gen_q     <= gen;
      enc_q     <= encrypt;
      dec_q     <= decrypt;
      gen_start <= gen_start_d;
      enc_start <= enc_start_d;
      dec_start <= dec_start_d;
      busy      <= busy_d;
      cmd_ok    <= cmd_ok_d;
      key_valid <= key_valid_d;
      ct_valid  <= ct_valid_d;
      err_code  <= err_code_d;
    end
  end

endmodule
